// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction memory request/response, redirect, and the
// decoded-instruction handshake toward the core.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher with credit-limited in-flight requests and an
// in-order {pc, word} prefetch FIFO; redirects flush the FIFO and drop stale responses.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];

  logic req, grant, resp, push, pop, valid;

  always_comb begin
    // Credit covers both buffered words and fetches whose response is still pending.
    req   = !rst && !bus.redirect && ((count_q + outst_q) < CW'(DEPTH));
    grant = req && bus.imem_gnt;
    resp  = bus.imem_rvalid && (outst_q != '0);
    valid = !rst && (count_q != '0);
    push  = resp && (drop_q == '0) && !bus.redirect;
    pop   = valid && bus.inst_ready && !bus.redirect;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      resp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = outst_q - CW'(resp);
      drop_d     = outst_q - CW'(resp);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CW'(grant) - CW'(resp);
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        word_mem_q[i] <= '0;
      end
    end else begin
      assert (!(bus.imem_rvalid && (outst_q == '0)));
      assert (!(push && (count_q == CW'(DEPTH))));
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        word_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = valid;
  assign bus.inst_out   = word_mem_q[rd_ptr_q];
  assign bus.inst_pc    = pc_mem_q[rd_ptr_q];
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of the single-cycle core's decode and control path. It generates sequential fetch addresses and issues them to a latency-tolerant instruction memory over a request/grant and response-valid handshake. Returned words are buffered with their PCs in a small in-order prefetch FIFO. On a branch or jump redirect it flushes the FIFO and discards responses still in flight.

Parameters:
DEPTH, 4, prefetch FIFO entries; also the cap on queued plus in-flight fetches (power of two, 2..16).
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address; word aligned.
imem_gnt  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response word valid; responses return in request order, latency of 1 or more cycles.
imem_rdata  in  32  response instruction word.
redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
inst_valid  out  1  FIFO head holds a valid instruction.
inst_out  out  32  head instruction word.
inst_pc  out  32  PC of the head instruction.
inst_ready  in  1  consumer takes the head this cycle.

Behaviour:
- State: fetch_pc, resp_pc, FIFO of {pc, word} × DEPTH, count (0..DEPTH), outst (0..DEPTH), drop (0..DEPTH).
- Reset values: fetch_pc = resp_pc = RESET_PC, count = outst = drop = 0. While rst is high, inst_valid = 0 and imem_req = 0. inst_out and inst_pc read 0 after reset until the first push.
- imem_req is combinational: high when !rst, !redirect, and count + outst < DEPTH.
- imem_addr = fetch_pc. It stays stable while imem_req is high and imem_gnt is low.
- Grant (imem_req && imem_gnt): fetch_pc += 4 (mod 2^32, wraps silently) and outst increments.
- Response (imem_rvalid) always decrements outst.
  - If drop > 0: the word is discarded and drop decrements.
  - Otherwise: push {resp_pc, imem_rdata} and resp_pc += 4.
- Pop (inst_valid && inst_ready): the head advances. inst_valid = (count != 0).
- Push and pop in the same cycle are both legal. Count is unchanged, including when the FIFO is full or has one entry.
- Latency: a word received on cycle N is visible at the head no earlier than cycle N+1. There is no bypass from imem_rdata to inst_out.
- The credit rule (count + outst <= DEPTH) guarantees a push never finds the FIFO full. Overflow is unreachable; the bench must assert this.
- Redirect has highest priority. On that edge:
  - count is set to 0; a concurrent pop and any push are void.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_next = outst − rvalid (the response arriving in the redirect cycle is discarded).
  - outst_next = outst − rvalid.
  - imem_req is low in the redirect cycle, so no grant is taken.
- Back-to-back redirects: each one recomputes drop from the current outst. The last one wins.
- imem_rvalid with outst = 0 is a protocol violation. It is ignored with no state change and must be flagged by an assertion.
- rst asserted mid-operation: all state returns to reset values on that edge. Responses to pre-reset requests are the memory's responsibility and must not arrive after reset.
- Size target: 150–250 lines of RTL.

Test Plan:
- Reset, then rst=0, imem_gnt=1, 1-cycle response latency, inst_ready=1 -> imem_addr 0x0, 0x4, 0x8… on consecutive cycles; inst_pc follows the same sequence, 2 cycles behind, one instruction per cycle.
- inst_ready=0, gnt always 1 -> exactly 4 grants, then imem_req stays low; count=4, inst_pc=0x0 held. Raise inst_ready -> one pop per cycle, and imem_req returns the cycle after the first pop.
- 3 requests outstanding (latency 5), redirect with redirect_pc=0x1003 -> FIFO empty next cycle; the next 3 responses are dropped; first delivered instruction has inst_pc=0x1000; next imem_addr=0x1000.
- Redirect in the same cycle as imem_rvalid, inst_ready=1 and a non-empty FIFO -> no pop and no push, drop = outst−1, inst_valid=0 next cycle.
- Random gnt (50%) and latency 1–6, with random redirects and inst_ready -> the delivered {pc, word} stream matches the reference model; no overflow; outst never exceeds DEPTH.
- fetch_pc = 0xFFFFFFFC, grant -> next imem_addr = 0x00000000; rst pulsed mid-stream -> next request address = RESET_PC and inst_valid=0.
